// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bus bundle between two masters, the arbiter and the memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          m0_req;
  logic          m1_req;
  logic          m0_write;
  logic          m1_write;
  logic [AW-1:0] m0_address;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt;
  logic          m1_gnt;
  logic          m0_done;
  logic          m1_done;
  logic [DW-1:0] m0_rdata;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] address;
  logic          write;
  logic [DW-1:0] to_memory;
  logic [DW-1:0] from_memory;
  logic          owner;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, m0_write, m1_write, m0_address, m1_address,
           m0_wdata, m1_wdata, from_memory,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           address, write, to_memory, owner
  );

  // Environment side: both masters plus the memory
  modport master (
    output m0_req, m1_req, m0_write, m1_write, m0_address, m1_address,
           m0_wdata, m1_wdata, from_memory,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           address, write, to_memory, owner
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin two-master arbiter for one memory port, with bursts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int             c_beat_w   = $clog2(MAX_BURST + 1);
  localparam logic [c_beat_w-1:0] c_max_beat = c_beat_w'(MAX_BURST);
  localparam logic [c_beat_w-1:0] c_one_beat = c_beat_w'(1);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic [c_beat_w-1:0] beat_q, beat_d;
  logic [AW-1:0]       address_q, address_d;
  logic                write_q, write_d;
  logic [DW-1:0]       to_memory_q, to_memory_d;
  logic                acc_write_q, acc_write_d;
  logic                m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic [DW-1:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic arb_edge;
  logic any_req;
  logic in_burst;
  logic winner;

  // Arbitration decode; a zero beat count means nobody owns a burst yet
  always_comb begin
    arb_edge = (state_q == c_idle) || (state_q == c_resp);
    any_req  = bus.m0_req | bus.m1_req;
    in_burst = (owner_q ? bus.m1_req : bus.m0_req)
               && (beat_q != '0) && (beat_q < c_max_beat);
    if (bus.m0_req && !bus.m1_req) begin
      winner = 1'b0;
    end else if (bus.m1_req && !bus.m0_req) begin
      winner = 1'b1;
    end else begin
      winner = in_burst ? owner_q : ~owner_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= c_idle;
      owner_q     <= 1'b1;
      beat_q      <= '0;
      address_q   <= '0;
      write_q     <= 1'b0;
      to_memory_q <= '0;
      acc_write_q <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      address_q   <= address_d;
      write_q     <= write_d;
      to_memory_q <= to_memory_d;
      acc_write_q <= acc_write_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_access:       state_d = c_resp;
      c_idle, c_resp: state_d = any_req ? c_access : c_idle;
      default:        state_d = c_idle;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    beat_d      = beat_q;
    address_d   = address_q;
    write_d     = 1'b0;
    to_memory_d = to_memory_q;
    acc_write_d = acc_write_q;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    // Completion of the access now in RESP
    if (state_q == c_resp) begin
      if (owner_q) begin
        m1_done_d = 1'b1;
        if (!acc_write_q) m1_rdata_d = bus.from_memory;
      end else begin
        m0_done_d = 1'b1;
        if (!acc_write_q) m0_rdata_d = bus.from_memory;
      end
    end

    if (arb_edge && any_req) begin
      owner_d = winner;
      if (winner != owner_q) begin
        beat_d = c_one_beat;
      end else if (beat_q != c_max_beat) begin
        beat_d = beat_q + c_one_beat;
      end
      address_d   = winner ? bus.m1_address : bus.m0_address;
      to_memory_d = winner ? bus.m1_wdata   : bus.m0_wdata;
      write_d     = winner ? bus.m1_write   : bus.m0_write;
      acc_write_d = write_d;
    end

    m0_gnt_d = (state_d != c_idle) && !owner_d;
    m1_gnt_d = (state_d != c_idle) &&  owner_d;
  end

  assign bus.address   = address_q;
  assign bus.write     = write_q;
  assign bus.to_memory = to_memory_q;
  assign bus.owner     = owner_q;
  assign bus.m0_gnt    = m0_gnt_q;
  assign bus.m1_gnt    = m1_gnt_q;
  assign bus.m0_done   = m0_done_q;
  assign bus.m1_done   = m1_done_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and random checks of mem_arbiter against an access-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory attached to the port, with a backdoor for preloading
  logic [DW-1:0] mem [256];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    bus.from_memory <= mem[bus.address];
    if (bd_we)          mem[bd_addr]     <= bd_data;
    else if (bus.write) mem[bus.address] <= bus.to_memory;
  end

  int checks = 0;
  int errors = 0;

  // Access-level reference model
  logic [DW-1:0] ref_mem [256];
  int            edge_n;
  int            next_arb;
  int            g_edge;
  bit            g_who, g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  bit            m_owner;
  int            m_beat;
  bit            e_done0, e_done1;
  logic [DW-1:0] e_rdata0, e_rdata1;
  bit            granted [2];
  bit            inflight [2];

  // Stimulus state of the two masters
  int  left [2];
  int  pct [2];
  int  maxlen;
  bit  polite;
  int  done_who [$];
  int  done_at [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_arb = 0; g_edge = -10; g_who = 0; g_wr = 0; g_addr = '0; g_data = '0;
    m_owner = 1'b1; m_beat = 0;
    e_done0 = 0; e_done1 = 0; e_rdata0 = '0; e_rdata1 = '0;
    for (int x = 0; x < 2; x++) begin
      granted[x] = 0; inflight[x] = 0; left[x] = 0;
    end
  endtask

  task automatic model_edge();
    logic r0, r1;
    bit   w;
    edge_n++;
    e_done0 = 0; e_done1 = 0; granted[0] = 0; granted[1] = 0;
    if (g_edge >= 0 && edge_n == g_edge + 1 && g_wr) ref_mem[g_addr] = g_data;
    if (g_edge >= 0 && edge_n == g_edge + 2) begin
      inflight[g_who] = 0;
      if (g_who) begin
        e_done1 = 1;
        if (!g_wr) e_rdata1 = ref_mem[g_addr];
      end else begin
        e_done0 = 1;
        if (!g_wr) e_rdata0 = ref_mem[g_addr];
      end
    end
    if (edge_n >= next_arb) begin
      r0 = bus.m0_req;
      r1 = bus.m1_req;
      if (r0 || r1) begin
        if (r0 && r1) w = (m_beat > 0 && m_beat < MAX_BURST) ? m_owner : !m_owner;
        else          w = r1;
        if (w == m_owner) m_beat = (m_beat < MAX_BURST) ? m_beat + 1 : MAX_BURST;
        else              m_beat = 1;
        m_owner  = w;
        g_edge   = edge_n;
        next_arb = edge_n + 2;
        g_who    = w;
        g_wr     = w ? bus.m1_write   : bus.m0_write;
        g_addr   = w ? bus.m1_address : bus.m0_address;
        g_data   = w ? bus.m1_wdata   : bus.m0_wdata;
        inflight[w] = 1;
        granted[w]  = 1;
      end
    end
  endtask

  task automatic check_cycle();
    bit act;
    act = (g_edge >= 0) && (edge_n - g_edge < 2);
    check("m0_gnt", bus.m0_gnt, act && !g_who);
    check("m1_gnt", bus.m1_gnt, act && g_who);
    check("gnt_exclusive", bus.m0_gnt & bus.m1_gnt, 0);
    check("write", bus.write, (g_edge >= 0) && (edge_n == g_edge) && g_wr);
    check("address", bus.address, g_addr);
    check("to_memory", bus.to_memory, g_data);
    check("owner", bus.owner, m_owner);
    check("m0_done", bus.m0_done, e_done0);
    check("m1_done", bus.m1_done, e_done1);
    check("m0_rdata", bus.m0_rdata, e_rdata0);
    check("m1_rdata", bus.m1_rdata, e_rdata1);
  endtask

  task automatic set_master(input int x, input logic rq, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (x == 0) begin
      bus.m0_req = rq; bus.m0_write = wr; bus.m0_address = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = rq; bus.m1_write = wr; bus.m1_address = a; bus.m1_wdata = d;
    end
  endtask

  task automatic new_fields(input int x);
    set_master(x, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
  endtask

  task automatic drop_req(input int x);
    if (x == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  task automatic issue(input int x, input int len, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    left[x] = len;
    set_master(x, 1'b1, wr, a, d);
  endtask

  // Masters react in the first gnt-high cycle: next beat or drop req
  task automatic drive();
    logic rq;
    for (int x = 0; x < 2; x++) begin
      rq = (x == 0) ? bus.m0_req : bus.m1_req;
      if (granted[x]) begin
        left[x]--;
        if (left[x] > 0) new_fields(x);
        else             drop_req(x);
      end else if (!rq && !(polite && inflight[x]) && $urandom_range(99) < pct[x]) begin
        left[x] = $urandom_range(maxlen, 1);
        new_fields(x);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
    if (bus.m0_done) begin done_who.push_back(0); done_at.push_back(edge_n); end
    if (bus.m1_done) begin done_who.push_back(1); done_at.push_back(edge_n); end
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk);
    check_cycle();
    reset = 1'b1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    ref_mem[a] = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < done_at.size(); i++) check(tag, done_at[i] - done_at[i-1], 2);
  endtask

  initial begin
    int gcnt, dcyc, wcnt, n0, n1;
    logic [DW-1:0] keep;
    reset = 1'b0;
    edge_n = 0;
    pct[0] = 0; pct[1] = 0; maxlen = 1; polite = 0;
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    for (int a = 0; a < 32; a++) poke(AW'(a), DW'($urandom));
    poke(8'h10, 8'hA5);
    do_reset();

    // Single read of 0x10 by m0
    issue(0, 1, 1'b0, 8'h10, '0);
    gcnt = 0; dcyc = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (bus.m0_gnt) gcnt++;
      if (bus.m0_done) begin
        dcyc = i;
        check("t1_rdata", bus.m0_rdata, 8'hA5);
      end
    end
    check("t1_gnt_cycles", gcnt, 2);
    check("t1_done_cycle", dcyc, 3);

    // m1 write then read back
    keep = bus.m1_rdata;
    issue(1, 1, 1'b1, 8'h20, 8'h3C);
    wcnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (bus.write) wcnt++;
      if (bus.m1_done) check("t2_rdata_held", bus.m1_rdata, keep);
    end
    check("t2_write_cycles", wcnt, 1);
    issue(1, 1, 1'b0, 8'h20, '0);
    for (int i = 0; i < 5; i++) cycle();
    check("t2_readback", bus.m1_rdata, 8'h3C);

    // Alternating single accesses from reset
    do_reset();
    pct[0] = 100; pct[1] = 100; maxlen = 1; polite = 1;
    done_who.delete(); done_at.delete();
    drive();
    for (int i = 0; i < 14; i++) cycle();
    check("alt_count", done_who.size() >= 6, 1);
    for (int i = 0; i < 6 && i < done_who.size(); i++) check("alt_order", done_who[i], i % 2);
    check_spacing("alt_spacing");
    pct[0] = 0; pct[1] = 0;
    for (int i = 0; i < 8; i++) cycle();

    // m0 burst of 6, m1 arrives during m0's first beat
    done_who.delete(); done_at.delete();
    issue(0, 6, 1'b0, 8'h05, '0);
    cycle();
    issue(1, 1, 1'b0, 8'h06, '0);
    for (int i = 0; i < 20; i++) cycle();
    check("burst_count", done_who.size(), 7);
    for (int i = 0; i < 7 && i < done_who.size(); i++)
      check("burst_order", done_who[i], (i == 4) ? 1 : 0);
    check_spacing("burst_spacing");

    // m0 sole requester for 10 beats
    done_who.delete(); done_at.delete();
    issue(0, 10, 1'b1, 8'h07, 8'h11);
    for (int i = 0; i < 26; i++) cycle();
    n0 = 0; n1 = 0;
    foreach (done_who[i]) if (done_who[i] == 0) n0++; else n1++;
    check("sole_m0_dones", n0, 10);
    check("sole_m1_dones", n1, 0);
    check_spacing("sole_spacing");

    // Random traffic
    polite = 0; maxlen = 6; pct[0] = 50; pct[1] = 50;
    for (int i = 0; i < 1500; i++) cycle();
    maxlen = 2; pct[0] = 90; pct[1] = 90;
    for (int i = 0; i < 500; i++) cycle();
    pct[0] = 0; pct[1] = 0;
    for (int i = 0; i < 40; i++) cycle();

    // Reset during the ACCESS cycle of an m1 write
    issue(1, 1, 1'b1, 8'h09, 8'h77);
    cycle();
    check("rst_pre_write", bus.write, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_write", bus.write, 0);
    check("rst_m1_gnt", bus.m1_gnt, 0);
    check("rst_m1_done", bus.m1_done, 0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_cycle();
    reset = 1'b1;
    check("rst_owner", bus.owner, 1);
    issue(0, 1, 1'b0, 8'h09, '0);
    issue(1, 1, 1'b0, 8'h0A, '0);
    cycle();
    check("rst_tie_m0", bus.m0_gnt, 1);
    for (int i = 0; i < 8; i++) cycle();
    check("rst_no_write", ref_mem[8'h09] === mem[8'h09], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single memory port (address, write, to_memory, from_memory) between the CPU and a second bus master such as a DMA or program loader. It sits between both masters and `memory`. It sequences each access as a fixed two-cycle transaction and grants the bus round-robin. A master holding its request may run a burst of consecutive beats, up to a configurable limit.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `MAX_BURST`, 4, max consecutive beats for one master while the other is requesting (>=1)

- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-low; clears all state immediately
- `m0_req`, `m1_req` in 1: access request, level-sampled
- `m0_write`, `m1_write` in 1: 1 = write, 0 = read
- `m0_address`, `m1_address` in AW: access address
- `m0_wdata`, `m1_wdata` in DW: write data
- `m0_gnt`, `m1_gnt` out 1: master owns the bus for the current access
- `m0_done`, `m1_done` out 1: one-cycle pulse, access complete
- `m0_rdata`, `m1_rdata` out DW: read data, valid while done is high, held until the next done
- `address` out AW: to memory
- `write` out 1: to memory, single-cycle strobe
- `to_memory` out DW: to memory write data
- `from_memory` in DW: memory read data, valid one cycle after the address is presented
- `owner` out 1: last granted master, 0 or 1

## Operation
- States: IDLE, ACCESS, RESP.
- Arbitration edge: any rising edge with the FSM in IDLE or RESP. At this edge, each `mX_req` is sampled as a request for a new access.
- Grant selection at an arbitration edge:
  - Only one master requesting: that master is granted.
  - Both requesting and the last owner still in a burst (owner's req high and beat count < MAX_BURST): the owner is granted again.
  - Otherwise (both requesting): the master that is not `owner` is granted.
- Winning request: address, write and wdata are latched into `address`/`write`/`to_memory`; `owner` updates; FSM goes to ACCESS.
- No request at an arbitration edge: FSM goes to IDLE; `address` and `to_memory` hold; `write` = 0.
- ACCESS → RESP, unconditionally. `write` falls to 0 at this edge, so memory sees exactly one write strobe per write access.
- RESP: `from_memory` is valid. At the edge leaving RESP, the owner's `rdata` is loaded from `from_memory` for reads only; `rdata` is unchanged on writes. The owner's `done` pulses high for the following cycle. That same edge is an arbitration edge.
- `mX_gnt` = (state is ACCESS or RESP) and `owner` == X. Registered, no glitches.
- Beat counter: set to 1 on a grant to a new owner, incremented on a re-grant to the same owner, saturating at MAX_BURST. Width: clog2(MAX_BURST+1).
- If only the owner is requesting, its bursts are unlimited. The counter saturates and has no effect.
- Master protocol:
  - Hold req, address, write and wdata stable until gnt is seen high.
  - A master wanting one access deasserts req in its first gnt-high cycle.
  - A master wanting a burst presents the next beat's fields before the end of RESP.
- Reset values: state IDLE, `owner` = 1 (so m0 wins the first tie), beat count 0, both gnt = 0, both done = 0, both rdata = 0, `address` = 0, `write` = 0, `to_memory` = 0.
- Reset mid-access: the access is abandoned, no done is issued, and `write` is forced to 0 asynchronously.

## Timing
- Request sampled at edge E0. gnt and memory outputs are valid in cycle E0–E1 (ACCESS).
- Memory samples address and write at E1. Read data is valid in cycle E1–E2 (RESP).
- done and rdata are valid in cycle E2–E3. Request-to-done latency is 3 cycles.
- Back-to-back accesses (burst or alternating masters): one access every 2 cycles, with no IDLE cycle between them.
- done for beat n coincides with the ACCESS cycle of beat n+1.
- Both masters are never granted in the same cycle. `write` is never high outside ACCESS.

## Test plan
- m0 reads address 0x10 holding 0xA5, single access: m0_gnt high for 2 cycles; write stays 0; m0_done high in the 3rd cycle after the req edge with m0_rdata = 0xA5.
- m1 writes 0x3C to 0x20, then m1 reads 0x20: write high for exactly 1 cycle; the read returns 0x3C; m1_rdata is unchanged on the write's done.
- Both masters request single accesses every cycle, starting from reset: grants alternate m0, m1, m0, m1, one per 2 cycles; gnt signals are never both high.
- MAX_BURST=4, m0 holds req continuously, m1 raises req during m0's first beat: m0 gets 4 beats, then m1 is granted, then m0 resumes. Done pulses arrive every 2 cycles with no gap.
- Assert reset in the ACCESS cycle of an m1 write: write, gnt and done drop to 0 immediately with no done pulse; after release, `owner` = 1 and a tie goes to m0.
- m0 sole requester holding req for 10 beats with MAX_BURST=4: 10 consecutive grants to m0 and 10 done pulses, not interrupted.
